product_seg_writer: RTL and testbench

- Writer side of the per-digit seven-segment holding registers in the 8x8 multiplier display path.
- Takes the 16-bit multiplier product on a start pulse and converts it to BCD with a sequential double-dabble (one bit per cycle).
- Encodes each digit to an active-low seven-segment pattern.
- Writes the digits one per cycle, units first, using the seg / seg_mux_sel / done bus that the digit registers capture.

---
 rtl/product_seg_writer.sv | 171 +++++++++++++++++
 tb/tb_product_seg_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_seg_writer.sv
// Writer side of the per-digit seven-segment registers: converts a 16-bit product
// to BCD by sequential double-dabble, then strobes one encoded digit per cycle, units first.
module product_seg_writer #(
   parameter int unsigned NUM_DIGITS = 5,
   parameter bit          BLANK_LZ   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] product,
   output logic        busy,
   output logic [6:0]  seg,
   output logic [2:0]  seg_mux_sel,
   output logic        done,
   output logic        finish
);

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      WRITE,
      FINISH,
      RELEASE
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

   state_t      state, state_nxt;
   logic [15:0] shift_q, shift_nxt;
   logic [19:0] bcd_q, bcd_nxt, bcd_adj;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [2:0]  idx, idx_nxt;
   logic        busy_nxt, done_nxt, finish_nxt;
   logic [6:0]  seg_nxt;
   logic [2:0]  sel_nxt;
   logic [3:0]  digit;
   logic        upper_zero;
   logic        blank;

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'b0000001;
         4'd1:    encode = 7'b1001111;
         4'd2:    encode = 7'b0010010;
         4'd3:    encode = 7'b0000110;
         4'd4:    encode = 7'b1001100;
         4'd5:    encode = 7'b0100100;
         4'd6:    encode = 7'b0100000;
         4'd7:    encode = 7'b0001111;
         4'd8:    encode = 7'b0000000;
         4'd9:    encode = 7'b0000100;
         default: encode = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction on every nibble in parallel, before the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Digit select plus "this and all higher digits are zero" for blanking
   always_comb begin
      digit      = bcd_q[3:0];
      upper_zero = 1'b0;
      case (idx)
         3'd1: begin
            digit      = bcd_q[7:4];
            upper_zero = (bcd_q[19:4] == '0);
         end
         3'd2: begin
            digit      = bcd_q[11:8];
            upper_zero = (bcd_q[19:8] == '0);
         end
         3'd3: begin
            digit      = bcd_q[15:12];
            upper_zero = (bcd_q[19:12] == '0);
         end
         3'd4: begin
            digit      = bcd_q[19:16];
            upper_zero = (bcd_q[19:16] == '0);
         end
         default: begin
            digit      = bcd_q[3:0];
            upper_zero = 1'b0;
         end
      endcase
      blank = BLANK_LZ && upper_zero;
   end

   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift_q;
      bcd_nxt     = bcd_q;
      bit_cnt_nxt = bit_cnt;
      idx_nxt     = idx;
      busy_nxt    = busy;
      seg_nxt     = seg;
      sel_nxt     = seg_mux_sel;
      done_nxt    = 1'b0;
      finish_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               shift_nxt   = product;
               bcd_nxt     = '0;
               bit_cnt_nxt = '0;
               idx_nxt     = '0;
               busy_nxt    = 1'b1;
               state_nxt   = CONVERT;
            end
         end
         CONVERT: begin
            bcd_nxt     = {bcd_adj[18:0], shift_q[15]};
            shift_nxt   = {shift_q[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
               idx_nxt   = '0;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            done_nxt = 1'b1;
            sel_nxt  = idx;
            seg_nxt  = blank ? '1 : encode(digit);
            idx_nxt  = idx + 3'd1;
            if (idx == LAST_IDX)
               state_nxt = FINISH;
         end
         FINISH: begin
            finish_nxt = 1'b1;
            state_nxt  = RELEASE;
         end
         RELEASE: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shift_q     <= '0;
         bcd_q       <= '0;
         bit_cnt     <= '0;
         idx         <= '0;
         busy        <= 1'b0;
         seg         <= '1;
         seg_mux_sel <= '0;
         done        <= 1'b0;
         finish      <= 1'b0;
      end else begin
         state       <= state_nxt;
         shift_q     <= shift_nxt;
         bcd_q       <= bcd_nxt;
         bit_cnt     <= bit_cnt_nxt;
         idx         <= idx_nxt;
         busy        <= busy_nxt;
         seg         <= seg_nxt;
         seg_mux_sel <= sel_nxt;
         done        <= done_nxt;
         finish      <= finish_nxt;
      end
   end

endmodule

// File: tb/tb_product_seg_writer.sv
// Scoreboard bench for product_seg_writer: blanking and non-blanking instances
// share stimulus; negedge monitors pop expected digit writes and finish pulses.
module tb_product_seg_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] product;

   logic        busy_a, done_a, finish_a;
   logic [6:0]  seg_a;
   logic [2:0]  sel_a;
   logic        busy_b, done_b, finish_b;
   logic [6:0]  seg_b;
   logic [2:0]  sel_b;

   int total = 0;
   int bad   = 0;
   int nda   = 0, nfa = 0, ndb = 0, nfb = 0;

   typedef struct {
      bit         fin;
      logic [2:0] sel;
      logic [6:0] seg;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   product_seg_writer #(.NUM_DIGITS(5), .BLANK_LZ(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .product(product),
      .busy(busy_a), .seg(seg_a), .seg_mux_sel(sel_a), .done(done_a), .finish(finish_a)
   );

   product_seg_writer #(.NUM_DIGITS(5), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .product(product),
      .busy(busy_b), .seg(seg_b), .seg_mux_sel(sel_b), .done(done_b), .finish(finish_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b0000001;
         4'd1:    seg_of = 7'b1001111;
         4'd2:    seg_of = 7'b0010010;
         4'd3:    seg_of = 7'b0000110;
         4'd4:    seg_of = 7'b1001100;
         4'd5:    seg_of = 7'b0100100;
         4'd6:    seg_of = 7'b0100000;
         4'd7:    seg_of = 7'b0001111;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0000100;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   // bcd holds the hand-computed decimal digits of the product
   task automatic push_exp(input logic [19:0] bcd, input int unsigned ndig, input bit with_fin);
      exp_t e;
      for (int unsigned k = 0; k < ndig; k++) begin
         logic [3:0]  d;
         logic [19:0] hi;
         d       = bcd[4*k +: 4];
         hi      = bcd >> (4 * k);
         e.fin   = 1'b0;
         e.sel   = 3'(k);
         e.seg   = (k > 0 && hi == '0) ? 7'b1111111 : seg_of(d);
         qa.push_back(e);
         e.seg   = seg_of(d);
         qb.push_back(e);
      end
      if (with_fin) begin
         e.fin = 1'b1;
         e.sel = '0;
         e.seg = '0;
         qa.push_back(e);
         qb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (done_a && finish_a) chk("a_overlap", 32'd1, 32'd0);
         if (done_a) nda++;
         if (finish_a) nfa++;
         if (done_a || finish_a) begin
            if (qa.size() == 0) chk("a_unexpected_strobe", {30'd0, done_a, finish_a}, 32'd0);
            else begin
               exp_t e;
               e = qa.pop_front();
               chk("a_kind", 32'(finish_a), 32'(e.fin));
               if (!e.fin) begin
                  chk("a_sel", 32'(sel_a), 32'(e.sel));
                  chk("a_seg", 32'(seg_a), 32'(e.seg));
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (done_b && finish_b) chk("b_overlap", 32'd1, 32'd0);
         if (done_b) ndb++;
         if (finish_b) nfb++;
         if (done_b || finish_b) begin
            if (qb.size() == 0) chk("b_unexpected_strobe", {30'd0, done_b, finish_b}, 32'd0);
            else begin
               exp_t e;
               e = qb.pop_front();
               chk("b_kind", 32'(finish_b), 32'(e.fin));
               if (!e.fin) begin
                  chk("b_sel", 32'(sel_b), 32'(e.sel));
                  chk("b_seg", 32'(seg_b), 32'(e.seg));
               end
            end
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_seg"},    32'(seg_a),    32'h7f);
      chk({tag, "_sel"},    32'(sel_a),    32'd0);
      chk({tag, "_done"},   32'(done_a),   32'd0);
      chk({tag, "_busy"},   32'(busy_a),   32'd0);
      chk({tag, "_finish"}, 32'(finish_a), 32'd0);
   endtask

   // Full sequence; dup pulses a second start with a different product mid-conversion
   task automatic run(input logic [15:0] p, input logic [19:0] bcd, input bit dup);
      int da0, fa0, db0, fb0;
      da0 = nda; fa0 = nfa; db0 = ndb; fb0 = nfb;
      push_exp(bcd, 5, 1'b1);
      @(negedge clk);
      product = p;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      product = ~p;
      chk("busy_after_accept", 32'(busy_a), 32'd1);
      for (int e = 1; e <= 23; e++) begin
         @(posedge clk);
         #1;
         if (dup && e == 5) begin
            start   = 1'b1;
            product = 16'h4321;
         end
         if (dup && e == 6) start = 1'b0;
         if (e == 16) chk("done_low_e16", 32'(done_a), 32'd0);
         if (e == 17) begin
            chk("done_high_e17", 32'(done_a), 32'd1);
            chk("sel0_e17", 32'(sel_a), 32'd0);
         end
         if (e == 21) chk("done_high_e21", 32'(done_a), 32'd1);
         if (e == 22) begin
            chk("finish_e22", 32'(finish_a), 32'd1);
            chk("done_low_e22", 32'(done_a), 32'd0);
            chk("busy_e22", 32'(busy_a), 32'd1);
            chk("sel_hold_e22", 32'(sel_a), 32'd4);
         end
         if (e == 23) begin
            chk("finish_low_e23", 32'(finish_a), 32'd0);
            chk("busy_low_e23", 32'(busy_a), 32'd0);
            chk("busy_b_low_e23", 32'(busy_b), 32'd0);
         end
      end
      chk("strobes_a", 32'(nda - da0), 32'd5);
      chk("finishes_a", 32'(nfa - fa0), 32'd1);
      chk("strobes_b", 32'(ndb - db0), 32'd5);
      chk("finishes_b", 32'(nfb - fb0), 32'd1);
      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);
   endtask

   task automatic run_abort(input logic [15:0] p, input logic [19:0] bcd);
      int da0, fa0;
      push_exp(bcd, 3, 1'b0);
      @(negedge clk);
      product = p;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int e = 1; e <= 19; e++) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_reset_vals("abort");
      chk("abort_b_seg", 32'(seg_b), 32'h7f);
      chk("abort_q_a", 32'(qa.size()), 32'd0);
      chk("abort_q_b", 32'(qb.size()), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      da0 = nda; fa0 = nfa;
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_strobes", 32'(nda - da0), 32'd0);
      chk("abort_no_finish", 32'(nfa - fa0), 32'd0);
      chk("abort_idle_busy", 32'(busy_a), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      product = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("in_reset");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_reset_vals("idle");
      end
      chk("idle_b_done", 32'(done_b), 32'd0);
      chk("idle_b_finish", 32'(finish_b), 32'd0);
      chk("idle_b_sel", 32'(sel_b), 32'd0);

      run(16'd65025, 20'h65025, 1'b0);
      run(16'd7,     20'h00007, 1'b0);
      run(16'd0,     20'h00000, 1'b0);
      run(16'd1005,  20'h01005, 1'b0);
      run(16'd12345, 20'h12345, 1'b1);
      run(16'd65535, 20'h65535, 1'b0);
      run_abort(16'd65025, 20'h65025);
      run(16'd99,    20'h00099, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
